// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM stage of the 16-bit WISC-S15 pipeline.
//
// Sits between the EX/MEM pipeline register and MEMWB_reg. A load or store is
// handled as a multi-cycle handshake with data memory. While the access is
// outstanding, the upstream stages are frozen and a bubble goes to MEMWB_reg.
// If no ack arrives after TIMEOUT busy cycles, the access is forced to
// complete: the read data becomes 16'hFFFF and a sticky error flag is set.
//
// Handshake: mem_req rises on the edge that leaves IDLE with an access. It
// stays high, with mem_addr/mem_we/mem_wdata held stable, until the edge that
// samples mem_ack=1 or until the timeout edge. mem_ack is a one-cycle strobe
// and is honoured only in BUSY.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   valid_in             EX/MEM holds a valid instruction
//   MemRead_in/MemWrite_in  load / store (both set => store)
//   RegWrite_in, ret_in, mem_to_reg_in, HALT_in, reg_rd_in, alu_result_in
//                        fields passed through to MEMWB_reg
//   store_data_in        store data
//   mem_rdata, mem_ack   memory response
//   mem_req, mem_we, mem_addr, mem_wdata   memory request
//   stall_out            freezes PC, IF/ID, ID/EX, EX/MEM
//   *_out                fields to MEMWB_reg
//   mem_err              sticky timeout flag (cleared only by reset)
//   dbg_state            current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        ret_in,
  input  logic        mem_to_reg_in,
  input  logic        HALT_in,
  input  logic [3:0]  reg_rd_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] store_data_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic        ret_out,
  output logic        mem_to_reg_out,
  output logic        HALT_out,
  output logic [3:0]  reg_rd_out,
  output logic [15:0] alu_result_out,
  output logic [15:0] mem_read_data_out,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value seen on the last allowed busy cycle (the TIMEOUT-th).
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [15:0] r_rdata_q;
  logic        w_access;

  // Gating with rst_n keeps stall_out low during reset, even when EX/MEM still
  // presents a memory instruction.
  assign w_access  = rst_n & valid_in & (MemRead_in | MemWrite_in);
  assign dbg_state = r_state;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_access) w_next = S_BUSY;
      S_BUSY: if (mem_ack || (r_cnt == LP_TO_LAST)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      r_rdata_q <= 16'h0000;
      r_cnt     <= 8'd0;
      mem_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            mem_addr  <= alu_result_in;
            mem_wdata <= store_data_in;
            mem_we    <= MemWrite_in;
            mem_req   <= 1'b1;
            r_cnt     <= 8'd0;
          end
        end
        S_BUSY: begin
          // The ack is checked first, so an ack on the timeout cycle wins.
          if (mem_ack) begin
            r_rdata_q <= mem_we ? 16'h0000 : mem_rdata;
            mem_req   <= 1'b0;
            r_cnt     <= 8'd0;
          end else if (r_cnt == LP_TO_LAST) begin
            r_rdata_q <= 16'hFFFF;
            mem_err   <= 1'b1;
            mem_req   <= 1'b0;
            r_cnt     <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    stall_out         = 1'b0;
    RegWrite_out      = RegWrite_in & valid_in;
    ret_out           = ret_in & valid_in;
    HALT_out          = HALT_in & valid_in;
    mem_to_reg_out    = mem_to_reg_in;
    reg_rd_out        = reg_rd_in;
    alu_result_out    = alu_result_in;
    mem_read_data_out = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          stall_out      = 1'b1;
          RegWrite_out   = 1'b0;
          ret_out        = 1'b0;
          HALT_out       = 1'b0;
          mem_to_reg_out = 1'b0;
        end
      end
      S_BUSY: begin
        stall_out      = 1'b1;
        RegWrite_out   = 1'b0;
        ret_out        = 1'b0;
        HALT_out       = 1'b0;
        mem_to_reg_out = 1'b0;
      end
      S_DONE: begin
        // Upstream was frozen, so the *_in fields still belong to this access.
        mem_read_data_out = r_rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// The stimulus tasks push the expected MEMWB record into exp_q. A monitor pops
// and compares a record whenever the DUT presents a valid, unstalled
// instruction to MEMWB.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic        RegWrite_in = 1'b0, ret_in = 1'b0, mem_to_reg_in = 1'b0, HALT_in = 1'b0;
  logic [3:0]  reg_rd_in = 4'h0;
  logic [15:0] alu_result_in = 16'h0, store_data_in = 16'h0, mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, stall_out, mem_err;
  logic [15:0] mem_addr, mem_wdata, alu_result_out, mem_read_data_out;
  logic        RegWrite_out, ret_out, mem_to_reg_out, HALT_out;
  logic [3:0]  reg_rd_out;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] alu;
    logic [3:0]  rd;
    logic [15:0] rdata;
    logic        rw;
    logic        m2r;
    logic        halt;
    logic        ret;
  } exp_t;

  exp_t exp_q[$];

  mem_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .ret_in(ret_in), .mem_to_reg_in(mem_to_reg_in),
    .HALT_in(HALT_in), .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall_out(stall_out), .RegWrite_out(RegWrite_out), .ret_out(ret_out),
    .mem_to_reg_out(mem_to_reg_out), .HALT_out(HALT_out), .reg_rd_out(reg_rd_out),
    .alu_result_out(alu_result_out), .mem_read_data_out(mem_read_data_out),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst_n && valid_in && !stall_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("alu_result_out", {16'h0, alu_result_out}, {16'h0, e.alu});
        check("reg_rd_out", {28'h0, reg_rd_out}, {28'h0, e.rd});
        check("mem_read_data_out", {16'h0, mem_read_data_out}, {16'h0, e.rdata});
        check("ctrl_out", {28'h0, RegWrite_out, mem_to_reg_out, HALT_out, ret_out},
              {28'h0, e.rw, e.m2r, e.halt, e.ret});
      end
    end else if (rst_n && stall_out) begin
      check("bubble_ctrl", {28'h0, RegWrite_out, mem_to_reg_out, HALT_out, ret_out}, 32'h0);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic clear_inputs();
    valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    RegWrite_in = 1'b0; ret_in = 1'b0; mem_to_reg_in = 1'b0; HALT_in = 1'b0;
    reg_rd_in = 4'h0; alu_result_in = 16'h0; store_data_in = 16'h0;
  endtask

  // One non-memory instruction, presented for exactly one cycle.
  task automatic pass_through(input logic [3:0] rd, input logic [15:0] alu,
                              input logic rw, input logic halt, input logic ret);
    exp_t e;
    @(posedge clk); #1;
    valid_in = 1'b1; RegWrite_in = rw; HALT_in = halt; ret_in = ret;
    mem_to_reg_in = 1'b0; reg_rd_in = rd; alu_result_in = alu;
    e = '{alu: alu, rd: rd, rdata: 16'h0, rw: rw, m2r: 1'b0, halt: halt, ret: ret};
    exp_q.push_back(e);
    @(negedge clk);
    check("pass_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // One load/store. ack_at = busy cycle on which mem_ack is pulsed (0 = never).
  task automatic do_access(input string tag, input bit is_wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int ack_at, input logic [15:0] exp_rd, input int exp_stall);
    int stall_n = 0;
    int req_n = 0;
    bit bad = 1'b0;
    bit done = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    valid_in = 1'b1; MemRead_in = !is_wr; MemWrite_in = is_wr;
    RegWrite_in = !is_wr; mem_to_reg_in = !is_wr; ret_in = 1'b0; HALT_in = 1'b0;
    reg_rd_in = 4'h5; alu_result_in = addr; store_data_in = wdata;
    e = '{alu: addr, rd: 4'h5, rdata: exp_rd, rw: !is_wr, m2r: !is_wr, halt: 1'b0, ret: 1'b0};
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!stall_out) begin
        done = 1'b1;
        mem_ack = 1'b0;
      end else begin
        stall_n++;
        if (mem_req) begin
          req_n++;
          if (mem_addr !== addr || mem_we !== is_wr || mem_wdata !== wdata) bad = 1'b1;
        end
        mem_ack   = mem_req && (req_n == ack_at);
        mem_rdata = rdata;
      end
    end
    mem_ack = 1'b0;
    check({tag, "_completed"}, {31'h0, done}, 32'h1);
    check({tag, "_stall_cycles"}, stall_n, exp_stall);
    check({tag, "_req_cycles"}, req_n, exp_stall - 1);
    check({tag, "_req_fields_stable"}, {31'h0, bad}, 32'h0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset state
    #2;
    check("rst_req_we", {30'h0, mem_req, mem_we}, 32'h0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
    check("rst_err_stall", {30'h0, mem_err, stall_out}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: pass-through, HALT pass-through, invalid instruction gating
    pass_through(4'h3, 16'h1234, 1'b1, 1'b0, 1'b0);
    pass_through(4'hA, 16'h00FF, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0; RegWrite_in = 1'b1; HALT_in = 1'b1; ret_in = 1'b1; alu_result_in = 16'h7777;
    @(negedge clk);
    check("invalid_ctrl_zero", {29'h0, RegWrite_out, HALT_out, ret_out}, 32'h0);
    check("invalid_alu_pass", {16'h0, alu_result_out}, 32'h7777);
    @(posedge clk); #1;
    clear_inputs();

    // 2: load, ack on 3rd busy cycle
    do_access("load3", 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3, 16'hBEEF, 4);
    check("load3_back_idle", {30'h0, dbg_state}, 32'h0);

    // 3: store, ack on 1st busy cycle
    do_access("store1", 1'b1, 16'h0100, 16'hA5A5, 16'h1111, 1, 16'h0000, 2);
    // both read and write set: treated as a store
    @(posedge clk); #1;
    valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b1; reg_rd_in = 4'h5;
    alu_result_in = 16'h0200; store_data_in = 16'h3C3C;
    exp_q.push_back('{alu: 16'h0200, rd: 4'h5, rdata: 16'h0, rw: 1'b0, m2r: 1'b0, halt: 1'b0, ret: 1'b0});
    @(negedge clk);
    @(negedge clk);
    check("rw_both_we", {31'h0, mem_we}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    clear_inputs();

    check("err_before_timeout", {31'h0, mem_err}, 32'h0);

    // 4: timeout, then a normal load; mem_err remains set
    do_access("timeout", 1'b0, 16'h0080, 16'h0000, 16'h0000, 0, 16'hFFFF, 16);
    check("err_after_timeout", {31'h0, mem_err}, 32'h1);
    do_access("load_after_to", 1'b0, 16'h0082, 16'h0000, 16'h1357, 2, 16'h1357, 3);
    check("err_sticky", {31'h0, mem_err}, 32'h1);

    // 5: reset mid-access, then spurious ack in IDLE
    @(posedge clk); #1;
    valid_in = 1'b1; MemRead_in = 1'b1; reg_rd_in = 4'h6; alu_result_in = 16'h0300;
    repeat (3) @(negedge clk);
    check("mid_busy_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, mem_req}, 32'h0);
    check("mid_rst_stall", {31'h0, stall_out}, 32'h0);
    check("mid_rst_err", {31'h0, mem_err}, 32'h0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 1'b0;
    check("spurious_state", {30'h0, dbg_state}, 32'h0);
    check("spurious_req", {31'h0, mem_req}, 32'h0);
    pass_through(4'h2, 16'h4321, 1'b1, 1'b0, 1'b0);

    // 6: ack on the timeout cycle wins
    do_access("ack_on_to", 1'b0, 16'h0090, 16'h0000, 16'h0001, 15, 16'h0001, 16);
    check("ack_on_to_err", {31'h0, mem_err}, 32'h0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
